// File: rtl/gray_stream_decoder.sv
// Gray-counter link receiver: two-stage Gray-to-binary decode, +1 step checker,
// SEARCH/TRACK/LOCKED lock tracker, wrap flag and saturating step-error counter.
module gray_stream_decoder #(
    parameter int N          = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         gray_in,
    input  logic                 gray_valid,
    input  logic                 clear_err,
    output logic [N-1:0]         bin_out,
    output logic                 bin_valid,
    output logic                 step_err,
    output logic                 wrap,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [N-1:0] ONE_N = N'(1);

    // Valid-only stream: a sample is taken whenever gray_valid is high; there is no backpressure.
    logic [N-1:0]     s1_g;
    logic             s1_v;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     ref_q, ref_d;
    logic [N-1:0]     b;
    logic [N-1:0]     ref_inc;
    logic             good, rpt;
    logic             err_d, wrap_d;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[i] = ^(s1_g >> i);
        end
    end

    always_comb begin
        ref_inc = ref_q + ONE_N;
        good    = (b == ref_inc);
        rpt     = (b == ref_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        if (s1_v) begin
            ref_d = b;
            case (state_q)
                SEARCH: begin
                    state_d = TRACK;
                    cnt_d   = '0;
                end
                TRACK: begin
                    if (good) begin
                        wrap_d = (b == '0);
                        if (cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (!rpt) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        wrap_d = (b == '0);
                    end else if (!rpt) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = TRACK;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_g      <= '0;
            s1_v      <= 1'b0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
            state_q   <= SEARCH;
            cnt_q     <= '0;
            ref_q     <= '0;
        end else begin
            s1_v <= gray_valid;
            if (gray_valid) begin
                s1_g <= gray_in;
            end
            bin_valid <= s1_v;
            if (s1_v) begin
                bin_out <= b;
            end
            step_err <= err_d;
            wrap     <= wrap_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            // Lags the state by one cycle so it changes after the deciding bin_valid.
            locked   <= (state_q == LOCKED);
            if (clear_err) begin
                err_count <= '0;
            end else if (err_d && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: lock-up, wrap, step errors, repeats,
// gaps, error-counter saturation/clear and reset with samples in flight.
module tb_gray_stream_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] gray_in;
    logic       gray_valid;
    logic       clear_err;

    logic [3:0] bin_out;
    logic       bin_valid, step_err, wrap, locked;
    logic [7:0] err_count;

    logic [3:0] bin_out_s;
    logic       bin_valid_s, step_err_s, wrap_s, locked_s;
    logic [1:0] err_count_s;

    int vectors;
    int miscompares;

    logic [3:0] gray_tab [16];

    gray_stream_decoder #(.N(4), .LOCK_COUNT(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
        .clear_err(clear_err), .bin_out(bin_out), .bin_valid(bin_valid),
        .step_err(step_err), .wrap(wrap), .locked(locked), .err_count(err_count)
    );

    gray_stream_decoder #(.N(4), .LOCK_COUNT(2), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
        .clear_err(clear_err), .bin_out(bin_out_s), .bin_valid(bin_valid_s),
        .step_err(step_err_s), .wrap(wrap_s), .locked(locked_s), .err_count(err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: apply inputs, take the edge, settle 1ns past it.
    task automatic drive(input logic [3:0] g, input logic v, input logic clr, input logic rst);
        gray_in    = g;
        gray_valid = v;
        clear_err  = clr;
        reset      = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        vectors++; if (bin_out !== 4'd0) begin miscompares++; $display("FAIL reset bin_out got %0d exp 0", bin_out); end
        vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL reset bin_valid got %b exp 0", bin_valid); end
        vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL reset step_err got %b exp 0", step_err); end
        vectors++; if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset wrap got %b exp 0", wrap); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset locked got %b exp 0", locked); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset err_count got %0d exp 0", err_count); end
        vectors++; if (err_count_s !== 2'd0) begin miscompares++; $display("FAIL reset err_count_s got %0d exp 0", err_count_s); end
    endtask

    task automatic test_basic();
        logic [3:0] g  [4];
        logic [3:0] eb [4];
        logic       el [4];
        g  = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        eb = '{4'd0, 4'd1, 4'd2, 4'd3};
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(g[k], 1'b1, 1'b0, 1'b0);
            else       drive(4'b0000, 1'b0, 1'b0, 1'b0);
            if (k == 0) begin
                vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL basic early bin_valid got %b exp 0", bin_valid); end
            end else if (k <= 4) begin
                vectors++; if (bin_valid !== 1'b1) begin miscompares++; $display("FAIL basic bin_valid k=%0d got %b exp 1", k, bin_valid); end
                vectors++; if (bin_out !== eb[k-1]) begin miscompares++; $display("FAIL basic bin_out k=%0d got %0d exp %0d", k, bin_out, eb[k-1]); end
                vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL basic step_err k=%0d got %b exp 0", k, step_err); end
                vectors++; if (locked !== el[k-1]) begin miscompares++; $display("FAIL basic locked k=%0d got %b exp %b", k, locked, el[k-1]); end
            end else begin
                vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL basic idle bin_valid got %b exp 0", bin_valid); end
                vectors++; if (bin_out !== 4'd3) begin miscompares++; $display("FAIL basic hold bin_out got %0d exp 3", bin_out); end
            end
        end
    endtask

    // Continues from bin 3 through 15, then 0 (wrap) and 1.
    task automatic test_wrap();
        logic [3:0] eb;
        for (int k = 0; k < 15; k++) begin
            if (k < 14) drive(gray_tab[(4 + k) % 16], 1'b1, 1'b0, 1'b0);
            else        drive(4'b0000, 1'b0, 1'b0, 1'b0);
            if (k >= 1) begin
                eb = 4'((4 + k - 1) % 16);
                vectors++; if (bin_valid !== 1'b1) begin miscompares++; $display("FAIL wrap bin_valid k=%0d got %b exp 1", k, bin_valid); end
                vectors++; if (bin_out !== eb) begin miscompares++; $display("FAIL wrap bin_out k=%0d got %0d exp %0d", k, bin_out, eb); end
                vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL wrap step_err k=%0d got %b exp 0", k, step_err); end
                vectors++; if (wrap !== (eb == 4'd0)) begin miscompares++; $display("FAIL wrap pulse k=%0d got %b exp %b", k, wrap, (eb == 4'd0)); end
                vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL wrap locked k=%0d got %b exp 1", k, locked); end
            end
        end
    endtask

    // From bin 1: 2, 3, 4, gap, 4 (repeat), gaps.
    task automatic test_repeat();
        logic       dv [7];
        logic [3:0] db [7];
        dv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        db = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
        for (int k = 0; k < 7; k++) begin
            drive(gray_tab[db[k]], dv[k], 1'b0, 1'b0);
            if (k >= 1) begin
                vectors++; if (bin_valid !== dv[k-1]) begin miscompares++; $display("FAIL repeat bin_valid k=%0d got %b exp %b", k, bin_valid, dv[k-1]); end
                vectors++; if (bin_out !== db[k-1]) begin miscompares++; $display("FAIL repeat bin_out k=%0d got %0d exp %0d", k, bin_out, db[k-1]); end
                vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL repeat step_err k=%0d got %b exp 0", k, step_err); end
                vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL repeat locked k=%0d got %b exp 1", k, locked); end
            end
        end
    endtask

    // From bin 4: 5 (good), 8 (error), 9, 10 (relock).
    task automatic test_error();
        logic [3:0] eb [4];
        logic       ee [4];
        logic       el [4];
        eb = '{4'd5, 4'd8, 4'd9, 4'd10};
        ee = '{1'b0, 1'b1, 1'b0, 1'b0};
        el = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(gray_tab[eb[k]], 1'b1, 1'b0, 1'b0);
            else       drive(4'b0000, 1'b0, 1'b0, 1'b0);
            if (k >= 1 && k <= 4) begin
                vectors++; if (bin_out !== eb[k-1]) begin miscompares++; $display("FAIL error bin_out k=%0d got %0d exp %0d", k, bin_out, eb[k-1]); end
                vectors++; if (step_err !== ee[k-1]) begin miscompares++; $display("FAIL error step_err k=%0d got %b exp %b", k, step_err, ee[k-1]); end
                vectors++; if (locked !== el[k-1]) begin miscompares++; $display("FAIL error locked k=%0d got %b exp %b", k, locked, el[k-1]); end
                vectors++; if (err_count !== 8'd1 && k >= 2) begin miscompares++; $display("FAIL error err_count k=%0d got %0d exp 1", k, err_count); end
            end
            if (k == 2) begin
                vectors++; if (err_count_s !== 2'd1) begin miscompares++; $display("FAIL error err_count_s got %0d exp 1", err_count_s); end
            end
            if (k == 5) begin
                vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL error relock got %b exp 1", locked); end
                vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL error idle bin_valid got %b exp 0", bin_valid); end
            end
        end
    endtask

    // From bin 10: clear, then alternate 0/5 so every step is illegal.
    task automatic test_saturate();
        logic [7:0] e8 [6];
        logic [1:0] e2 [6];
        e8 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        e2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL sat clear err_count got %0d exp 0", err_count); end
        vectors++; if (err_count_s !== 2'd0) begin miscompares++; $display("FAIL sat clear err_count_s got %0d exp 0", err_count_s); end
        for (int k = 0; k < 7; k++) begin
            // clear_err lands on the same edge that reports the sixth error.
            if (k < 6) drive(gray_tab[(k % 2 == 0) ? 0 : 5], 1'b1, 1'b0, 1'b0);
            else       drive(4'b0000, 1'b0, 1'b1, 1'b0);
            if (k >= 1) begin
                vectors++; if (step_err !== 1'b1) begin miscompares++; $display("FAIL sat step_err k=%0d got %b exp 1", k, step_err); end
                vectors++; if (err_count !== e8[k-1]) begin miscompares++; $display("FAIL sat err_count k=%0d got %0d exp %0d", k, err_count, e8[k-1]); end
                vectors++; if (err_count_s !== e2[k-1]) begin miscompares++; $display("FAIL sat err_count_s k=%0d got %0d exp %0d", k, err_count_s, e2[k-1]); end
            end
        end
    endtask

    // Sample 6 in stage 1 and sample 7 at the input when reset hits; ref is 5.
    task automatic test_reset_inflight();
        drive(gray_tab[6], 1'b1, 1'b0, 1'b0);
        drive(gray_tab[7], 1'b1, 1'b0, 1'b1);
        vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL inflight bin_valid got %b exp 0", bin_valid); end
        vectors++; if (bin_out !== 4'd0) begin miscompares++; $display("FAIL inflight bin_out got %0d exp 0", bin_out); end
        vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL inflight step_err got %b exp 0", step_err); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL inflight locked got %b exp 0", locked); end
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            drive(4'b0000, 1'b0, 1'b0, 1'b0);
            vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL inflight release bin_valid k=%0d got %b exp 0", k, bin_valid); end
        end
        drive(gray_tab[9], 1'b1, 1'b0, 1'b0);
        vectors++; if (bin_valid !== 1'b0) begin miscompares++; $display("FAIL inflight first bin_valid got %b exp 0", bin_valid); end
        drive(gray_tab[10], 1'b1, 1'b0, 1'b0);
        vectors++; if (bin_valid !== 1'b1) begin miscompares++; $display("FAIL inflight search bin_valid got %b exp 1", bin_valid); end
        vectors++; if (bin_out !== 4'd9) begin miscompares++; $display("FAIL inflight search bin_out got %0d exp 9", bin_out); end
        vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL inflight search step_err got %b exp 0", step_err); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL inflight search locked got %b exp 0", locked); end
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        vectors++; if (bin_out !== 4'd10) begin miscompares++; $display("FAIL inflight track bin_out got %0d exp 10", bin_out); end
        vectors++; if (step_err !== 1'b0) begin miscompares++; $display("FAIL inflight track step_err got %b exp 0", step_err); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL inflight track locked got %b exp 0", locked); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL inflight err_count got %0d exp 0", err_count); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        reset      = 1'b1;
        gray_in    = 4'b0000;
        gray_valid = 1'b0;
        clear_err  = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_repeat();
        test_error();
        test_saturate();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
